// File: rtl/usb_nrzi_rx_decoder.sv
// USB NRZI receive decoder: NRZI decode, bit-unstuffing and LSB-first deserialisation.
// Optional EOP-misalignment detection is enabled by defining USB_DECODER_ALIGN_ERR_EN.
module usb_nrzi_rx_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int STUFF_LEN  = 6,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  d_plus_sync,
  input  logic                  shift_enable,
  input  logic                  eop,
  input  logic                  clear,
  output logic                  d_orig,
  output logic                  bit_valid,
  output logic [DATA_WIDTH-1:0] rx_word,
  output logic                  word_ready,
  output logic                  stuff_err,
  output logic                  align_err
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  logic                  prev_level;
  logic [ONES_W-1:0]     ones_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic                  eop_strobe;
  logic                  bit_strobe;
  logic                  stuff_slot;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] shift_nxt;

  assign eop_strobe = shift_enable & eop;
  assign bit_strobe = shift_enable & ~eop;
  assign stuff_slot = (ones_cnt == ONES_W'(STUFF_LEN));

  // No level change decodes as 1; an EOP strobe is forced to read as 1.
  assign d_orig    = eop_strobe | ~(d_plus_sync ^ prev_level);
  assign bit_valid = bit_strobe & ~stuff_slot;
  assign shift_nxt = {d_orig, shift_reg[DATA_WIDTH-1:1]};
  assign word_done = bit_valid & (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev_level <= IDLE_LEVEL;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_word    <= '0;
      word_ready <= 1'b0;
      stuff_err  <= 1'b0;
    end else if (clear) begin
      prev_level <= IDLE_LEVEL;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      word_ready <= 1'b0;
      stuff_err  <= 1'b0;
    end else if (eop_strobe) begin
      prev_level <= IDLE_LEVEL;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      word_ready <= 1'b0;
    end else if (bit_strobe) begin
      // Line level is tracked even across a dropped stuff bit.
      prev_level <= d_plus_sync;
      if (stuff_slot) begin
        ones_cnt   <= '0;
        word_ready <= 1'b0;
        if (d_orig) stuff_err <= 1'b1;
      end else begin
        ones_cnt  <= d_orig ? ones_cnt + ONES_W'(1) : '0;
        shift_reg <= shift_nxt;
        if (word_done) begin
          rx_word    <= shift_nxt;
          bit_cnt    <= '0;
          word_ready <= 1'b1;
        end else begin
          bit_cnt    <= bit_cnt + BIT_W'(1);
          word_ready <= 1'b0;
        end
      end
    end else begin
      word_ready <= 1'b0;
    end
  end

`ifdef USB_DECODER_ALIGN_ERR_EN
  // An EOP arriving with a partial word in flight means the packet was not word aligned.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      align_err <= 1'b0;
    end else if (clear) begin
      align_err <= 1'b0;
    end else if (eop_strobe && (bit_cnt != '0)) begin
      align_err <= 1'b1;
    end
  end
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_nrzi_rx_decoder.sv
// Self-checking bench for usb_nrzi_rx_decoder: vector table, scoreboard of expected words,
// and hand-written sequences for stuffing, EOP, reset and a 16-bit instance.
module tb_usb_nrzi_rx_decoder;

`ifdef USB_DECODER_ALIGN_ERR_EN
  localparam logic ALIGN_EXP = 1'b1;
`else
  localparam logic ALIGN_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic d_plus_sync = 1'b1;
  logic shift_enable = 1'b0;
  logic eop = 1'b0;
  logic clear = 1'b0;

  logic        d_orig, bit_valid, word_ready, stuff_err, align_err;
  logic [7:0]  rx_word;
  logic        d_orig16, bit_valid16, word_ready16, stuff_err16, align_err16;
  logic [15:0] rx_word16;

  usb_nrzi_rx_decoder #(.DATA_WIDTH(8), .STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .d_plus_sync(d_plus_sync), .shift_enable(shift_enable),
    .eop(eop), .clear(clear), .d_orig(d_orig), .bit_valid(bit_valid), .rx_word(rx_word),
    .word_ready(word_ready), .stuff_err(stuff_err), .align_err(align_err)
  );

  usb_nrzi_rx_decoder #(.DATA_WIDTH(16), .STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut16 (
    .clk(clk), .n_rst(n_rst), .d_plus_sync(d_plus_sync), .shift_enable(shift_enable),
    .eop(eop), .clear(clear), .d_orig(d_orig16), .bit_valid(bit_valid16), .rx_word(rx_word16),
    .word_ready(word_ready16), .stuff_err(stuff_err16), .align_err(align_err16)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic en16 = 1'b0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];

  typedef struct {
    logic       clr;
    logic       dp;
    logic       ep;
    logic       exp_d;
    logic       exp_v;
    logic       push;
    logic [7:0] word;
  } vec_t;
  vec_t tbl[$];

  logic a5_dp[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic a5_d[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every word_ready pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (word_ready === 1'b1) begin
      if (q8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word8_unexpected: got word_ready=1 rx_word=%0h, required no word", rx_word);
      end else begin
        check("word8", {24'h0, rx_word}, {24'h0, q8.pop_front()});
      end
    end
    if (en16 && word_ready16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word16_unexpected: got word_ready=1 rx_word=%0h, required no word", rx_word16);
      end else begin
        check("word16", {16'h0, rx_word16}, {16'h0, q16.pop_front()});
      end
    end
  end

  task automatic strobe(input logic dp, input logic ep, input logic exp_d, input logic exp_v,
                        input string nm);
    @(negedge clk);
    d_plus_sync  = dp;
    shift_enable = 1'b1;
    eop          = ep;
    #1;
    check({nm, "_d_orig"}, {31'h0, d_orig}, {31'h0, exp_d});
    check({nm, "_bit_valid"}, {31'h0, bit_valid}, {31'h0, exp_v});
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
    eop          = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic send_a5(input string nm);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q8.push_back(8'hA5);
      strobe(a5_dp[i], 1'b0, a5_d[i], 1'b1, nm);
    end
  endtask

  task automatic add(input logic clr, input logic dp, input logic exp_d, input logic exp_v,
                     input logic push, input logic [7:0] word);
    vec_t v;
    v.clr = clr; v.dp = dp; v.ep = 1'b0; v.exp_d = exp_d; v.exp_v = exp_v;
    v.push = push; v.word = word;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Byte decode: line 1,0,0,1,0,0,1,1 from idle J gives 0xA5.
    for (int i = 0; i < 8; i++) add(1'b0, a5_dp[i], a5_d[i], 1'b1, i == 7, 8'hA5);
    // Six decoded ones, a stuffed transition, then two more ones gives 0xFF.
    for (int i = 0; i < 6; i++) add(i == 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);

    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_word", {24'h0, rx_word}, 32'h0);
    check("rst_word_ready", {31'h0, word_ready}, 32'h0);
    check("rst_stuff_err", {31'h0, stuff_err}, 32'h0);
    check("rst_align_err", {31'h0, align_err}, 32'h0);
    check("rst_d_orig_j", {31'h0, d_orig}, 32'h1);
    d_plus_sync = 1'b0;
    #1;
    check("rst_d_orig_k", {31'h0, d_orig}, 32'h0);
    check("idle_bit_valid", {31'h0, bit_valid}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    d_plus_sync = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].clr) do_clear();
      if (tbl[i].push) q8.push_back(tbl[i].word);
      strobe(tbl[i].dp, tbl[i].ep, tbl[i].exp_d, tbl[i].exp_v, $sformatf("vec%0d", i));
    end
    check("t2_stuff_err", {31'h0, stuff_err}, 32'h0);

    // Stuff violation: seventh consecutive one is dropped and flagged.
    do_clear();
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b1, i < 6, "t3");
    check("t3_stuff_err_set", {31'h0, stuff_err}, 32'h1);
    strobe(1'b1, 1'b0, 1'b1, 1'b1, "t3_more");
    q8.push_back(8'hFF);
    strobe(1'b1, 1'b0, 1'b1, 1'b1, "t3_more");
    repeat (2) @(posedge clk);
    #1;
    check("t3_stuff_err_sticky", {31'h0, stuff_err}, 32'h1);
    do_clear();
    check("t3_stuff_err_clr", {31'h0, stuff_err}, 32'h0);
    check("t3_rx_word_kept", {24'h0, rx_word}, 32'hFF);

    // EOP on a word boundary, then EOP after three bits.
    strobe(1'b0, 1'b1, 1'b1, 1'b0, "t4_eop0");
    check("t4_align_boundary", {31'h0, align_err}, 32'h0);
    strobe(1'b1, 1'b0, 1'b1, 1'b1, "t4");
    strobe(1'b0, 1'b0, 1'b0, 1'b1, "t4");
    strobe(1'b0, 1'b0, 1'b1, 1'b1, "t4");
    strobe(1'b0, 1'b1, 1'b1, 1'b0, "t4_eop");
    @(negedge clk);
    check("t4_rx_word_kept", {24'h0, rx_word}, 32'hFF);
    check("t4_word_ready", {31'h0, word_ready}, 32'h0);
    check("t4_align_err", {31'h0, align_err}, {31'h0, ALIGN_EXP});
    send_a5("t4_a5");
    repeat (2) @(posedge clk);
    #1;
    check("t4_align_sticky", {31'h0, align_err}, {31'h0, ALIGN_EXP});
    do_clear();
    check("t4_align_clr", {31'h0, align_err}, 32'h0);

    // A low pulse between edges must not reset anything.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q8.push_back(8'hA5);
      strobe(a5_dp[i], 1'b0, a5_d[i], 1'b1, "t5_glitch");
      if (i == 2) begin
        #1 n_rst = 1'b0;
        #2 n_rst = 1'b1;
      end
    end
    for (int i = 0; i < 5; i++) strobe(a5_dp[i], 1'b0, a5_d[i], 1'b1, "t5_part");
    @(negedge clk);
    n_rst = 1'b0;
    d_plus_sync = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rx_word", {24'h0, rx_word}, 32'h0);
    check("t5_word_ready", {31'h0, word_ready}, 32'h0);
    check("t5_stuff_err", {31'h0, stuff_err}, 32'h0);
    check("t5_align_err", {31'h0, align_err}, 32'h0);
    check("t5_prev_level", {31'h0, d_orig}, 32'h1);
    n_rst = 1'b1;
    send_a5("t5_a5");

    // 16-bit instance: alternating decoded bits 1,0,1,0... give 0x5555.
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    en16 = 1'b1;
    begin
      logic lvl;
      logic b;
      lvl = 1'b1;
      for (int i = 0; i < 16; i++) begin
        b = (i % 2 == 0);
        if (!b) lvl = ~lvl;
        if (i == 7 || i == 15) q8.push_back(8'h55);
        if (i == 15) q16.push_back(16'h5555);
        strobe(lvl, 1'b0, b, 1'b1, "t6");
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("t6_rx_word16", {16'h0, rx_word16}, 32'h5555);
    check("q8_drained", q8.size(), 32'h0);
    check("q16_drained", q16.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_nrzi_rx_decoder.md
Name: usb_nrzi_rx_decoder

Overview:
Parametrised successor to the single-bit USB NRZI decoder.
- Performs NRZI decode of the synchronised D+ line.
- Removes stuffed bits and flags bit-stuff violations.
- Deserialises the unstuffed stream, LSB-first, into DATA_WIDTH-bit words with a one-cycle ready strobe.
- Sits between the D+ synchroniser / edge detector (which supplies shift_enable at the bit rate) and the RX control FSM / RX FIFO.

Parameters:
DATA_WIDTH, 8, number of bits per deserialised word (2..32).
STUFF_LEN, 6, count of consecutive decoded 1s after which the next bit is a stuffed bit.
IDLE_LEVEL, 1, line level (J) loaded into the previous-level register on reset, clear and EOP.

Ports:
clk  input  1  system clock; all state updates on rising edge.
n_rst  input  1  synchronous active-low reset; sampled on rising clk edge.
d_plus_sync  input  1  synchronised D+ level.
shift_enable  input  1  one-cycle strobe marking the bit sample point.
eop  input  1  end-of-packet detected, qualified by shift_enable.
clear  input  1  synchronous re-arm from RX FSM at start of packet.
d_orig  output  1  combinational NRZI-decoded bit.
bit_valid  output  1  combinational; d_orig is a data bit this cycle (not stuffed, not EOP).
rx_word  output  DATA_WIDTH  last completed word, registered.
word_ready  output  1  registered one-cycle pulse when rx_word updates.
stuff_err  output  1  sticky bit-stuff violation flag.
align_err  output  1  sticky EOP-misalignment flag (see Optional Feature).

Behaviour:
- Reset: the reset interface is fixed as one clock; reset is synchronous and active-low. Values while n_rst=0 at an edge:
  - prev_level=IDLE_LEVEL, ones_cnt=0, bit_cnt=0, shift_reg=0.
  - rx_word=0, word_ready=0, stuff_err=0, align_err=0.
- Update priority per edge: n_rst > clear > (shift_enable & eop) > (shift_enable & !eop). With shift_enable=0 and no reset/clear, state holds and word_ready=0.
- d_orig:
  - Equals 1 when shift_enable & eop.
  - Otherwise equals ~(d_plus_sync ^ prev_level).
- prev_level:
  - On shift_enable & !eop: loads d_plus_sync, including on stuffed bits.
  - On shift_enable & eop, and on clear: loads IDLE_LEVEL.
- Stuffing, evaluated on shift_enable & !eop:
  - stuff_slot = (ones_cnt == STUFF_LEN).
  - If stuff_slot and d_orig=0: bit dropped, ones_cnt<=0.
  - If stuff_slot and d_orig=1: bit dropped, ones_cnt<=0, stuff_err<=1.
  - If not stuff_slot: ones_cnt<=d_orig ? ones_cnt+1 : 0.
  - ones_cnt width is clog2(STUFF_LEN+1).
- bit_valid = shift_enable & !eop & !stuff_slot.
- Deserialiser, on bit_valid:
  - shift_reg <= {d_orig, shift_reg[DATA_WIDTH-1:1]}, so the first bit received lands in bit 0.
  - bit_cnt increments.
  - When bit_cnt==DATA_WIDTH-1: rx_word <= {d_orig, shift_reg[DATA_WIDTH-1:1]}, word_ready<=1 for the following cycle only, and bit_cnt wraps to 0.
- EOP (shift_enable & eop):
  - bit_cnt<=0, ones_cnt<=0, prev_level<=IDLE_LEVEL.
  - Partial word discarded; rx_word unchanged; no word_ready.
- clear:
  - Same effect as EOP.
  - Also clears stuff_err and align_err.
  - rx_word is retained.
- Errors: stuff_err and align_err stay set until clear or reset. Receiving continues after an error.
- Back-to-back words: word_ready may pulse on every DATA_WIDTH-th valid bit with no dead cycle.
- Reset mid-word: all partial state is lost; the next bit after release starts at bit_cnt=0.

Optional Feature:
Macro USB_DECODER_ALIGN_ERR_EN.
- Defined: on shift_enable & eop with bit_cnt != 0, align_err<=1 (sticky).
- Undefined: align_err is tied to 0 and no extra logic is generated.
- The port list is identical in both builds.

Test Plan:
1. Byte decode. Defaults, after reset. Apply d_plus_sync = 1,0,0,1,0,0,1,1, each with one shift_enable pulse.
   -> rx_word=8'hA5; word_ready high for exactly 1 cycle after the 8th strobe; bit_valid on all 8 strobes.
2. Stuffed bit removal. Apply d_plus_sync = 1,1,1,1,1,1 (six 1s), then 0 (stuffed transition), then 0,0.
   -> bit_valid=0 on the 7th strobe only; rx_word=8'hFF after the 9th strobe; stuff_err=0.
3. Stuff violation. Hold d_plus_sync=1 for 7 strobes.
   -> 7th bit dropped; stuff_err=1 from the next cycle; it remains 1 through a further word; clear drops it to 0.
4. EOP mid-word. After 3 valid bits, pulse shift_enable with eop=1.
   -> d_orig=1, bit_valid=0, no word_ready; rx_word unchanged.
   -> align_err=1 only when USB_DECODER_ALIGN_ERR_EN is defined.
   -> A following 0xA5 sequence decodes correctly.
5. Synchronous reset. Pull n_rst=0 for one edge after 5 bits. Verify that an asynchronous low pulse not spanning an edge has no effect.
   -> All outputs 0 next cycle; prev_level=1.
   -> Next 8 bits form a full word with no leftover bits.
6. Width parameter. DATA_WIDTH=16, 16 alternating decoded bits.
   -> word_ready only after the 16th valid bit; rx_word=16'h5555 for bits 1,0,1,0...
